// File: rtl/timer_irq_source_if.sv
// Data-memory bus slice seen by the timer peripheral: address, strobes, store data and read data.
interface timer_irq_source_if;
  logic [31:0] addr;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, MemRead, MemWrite, wdata, input rdata);
  modport slave  (input addr, MemRead, MemWrite, wdata, output rdata);
endinterface

// File: rtl/timer_irq_source.sv
// Memory-mapped reload timer (TH reload, TL counter, TCON control) driving a level interrupt line.
module timer_irq_source #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int          PRESCALE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  timer_irq_source_if.slave    bus,
  output logic                 irq
);
  localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   LAST_TICK = PW'(PRESCALE - 1);
  localparam logic [31:0]     TH_ADDR   = BASE_ADDR & ~32'h3;
  localparam logic [31:0]     TL_ADDR   = TH_ADDR + 32'd4;
  localparam logic [31:0]     TCON_ADDR = TH_ADDR + 32'd8;

  logic [31:0]   thReg, thNext;
  logic [31:0]   tlReg, tlNext;
  logic [2:0]    tconReg, tconNext;
  logic [PW-1:0] preReg, preNext;
  logic [31:0]   wordAddr;
  logic          selTh, selTl, selTcon;
  logic          wrTh, wrTl, wrTcon;
  logic          stopNow, tick, overflow;

  always_comb begin
    wordAddr = bus.addr & ~32'h3;
    selTh    = (wordAddr == TH_ADDR);
    selTl    = (wordAddr == TL_ADDR);
    selTcon  = (wordAddr == TCON_ADDR);
    wrTh     = bus.MemWrite & selTh;
    wrTl     = bus.MemWrite & selTl;
    wrTcon   = bus.MemWrite & selTcon;
    // A store that clears enable wins over a tick landing on the same edge.
    stopNow  = wrTcon & ~bus.wdata[0];
    tick     = tconReg[0] & (preReg == LAST_TICK) & ~stopNow;
    overflow = tick & (tlReg == 32'hFFFF_FFFF);
  end

  always_comb begin
    preNext = preReg + PW'(1);
    if (!tconReg[0] || stopNow || tick)
      preNext = '0;

    thNext = wrTh ? bus.wdata : thReg;

    tlNext = tlReg;
    if (wrTl)
      tlNext = bus.wdata;
    else if (overflow)
      tlNext = thReg;
    else if (tick)
      tlNext = tlReg + 32'd1;

    tconNext = tconReg;
    if (wrTcon)
      tconNext = bus.wdata[2:0];
    // Pending is ORed in last so a same-edge software clear never drops an overflow.
    if (overflow && tconReg[1])
      tconNext[2] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      thReg   <= '0;
      tlReg   <= '0;
      tconReg <= '0;
      preReg  <= '0;
    end else begin
      thReg   <= thNext;
      tlReg   <= tlNext;
      tconReg <= tconNext;
      preReg  <= preNext;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.MemRead) begin
      if (selTh)
        bus.rdata = thReg;
      else if (selTl)
        bus.rdata = tlReg;
      else if (selTcon)
        bus.rdata = {29'b0, tconReg};
    end
  end

  assign irq = tconReg[1] & tconReg[2];
endmodule

// File: tb/tb_timer_irq_source.sv
// Directed vector bench for timer_irq_source: one DUT with PRESCALE=1, one with PRESCALE=4.
module tb_timer_irq_source;
  localparam logic [31:0] BASE = 32'h40000000;

  logic clk;
  logic reset;
  logic irq1, irq4;
  int   vecCount;
  int   missCount;

  timer_irq_source_if bus1 ();
  timer_irq_source_if bus4 ();

  timer_irq_source #(.BASE_ADDR(BASE), .PRESCALE(1)) u1 (
    .clk(clk), .reset(reset), .bus(bus1), .irq(irq1)
  );
  timer_irq_source #(.BASE_ADDR(BASE), .PRESCALE(4)) u4 (
    .clk(clk), .reset(reset), .bus(bus4), .irq(irq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut: 0 selects the PRESCALE=1 instance, 1 the PRESCALE=4 instance
  typedef struct {
    bit          dut;
    bit          rd;
    bit          wr;
    logic [7:0]  off;
    logic [31:0] wd;
    logic [31:0] expRd;
    bit          expIrq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit d, bit r, bit w, logic [7:0] o, logic [31:0] wd,
                              logic [31:0] er, bit ei);
    vec_t v;
    v.dut = d; v.rd = r; v.wr = w; v.off = o; v.wd = wd; v.expRd = er; v.expIrq = ei;
    return v;
  endfunction

  function automatic vec_t vr(bit d, logic [7:0] o, logic [31:0] er, bit ei);
    return mk(d, 1'b1, 1'b0, o, 32'h0, er, ei);
  endfunction
  function automatic vec_t vw(bit d, logic [7:0] o, logic [31:0] wd, bit ei);
    return mk(d, 1'b0, 1'b1, o, wd, 32'h0, ei);
  endfunction
  function automatic vec_t vrw(bit d, logic [7:0] o, logic [31:0] wd, logic [31:0] er, bit ei);
    return mk(d, 1'b1, 1'b1, o, wd, er, ei);
  endfunction
  function automatic vec_t vi(bit d, bit ei);
    return mk(d, 1'b0, 1'b0, 8'h0, 32'h0, 32'h0, ei);
  endfunction

  task automatic idleBuses();
    bus1.addr = BASE; bus1.MemRead = 1'b0; bus1.MemWrite = 1'b0; bus1.wdata = '0;
    bus4.addr = BASE; bus4.MemRead = 1'b0; bus4.MemWrite = 1'b0; bus4.wdata = '0;
  endtask

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("FAIL %s got %08h want %08h", name, act, exp);
    end else begin
      $display("chk %s = %08h ok", name, act);
    end
  endtask

  // Inputs go on at the falling edge; outputs are checked 1ns later, before the rising edge
  // that commits any write carried by this vector.
  task automatic applyVec(int idx, vec_t v);
    logic [31:0] actRd;
    logic        actIrq;
    @(negedge clk);
    idleBuses();
    if (v.dut == 1'b0) begin
      bus1.addr = BASE + {24'h0, v.off}; bus1.MemRead = v.rd;
      bus1.MemWrite = v.wr; bus1.wdata = v.wd;
    end else begin
      bus4.addr = BASE + {24'h0, v.off}; bus4.MemRead = v.rd;
      bus4.MemWrite = v.wr; bus4.wdata = v.wd;
    end
    #1;
    actRd  = v.dut ? bus4.rdata : bus1.rdata;
    actIrq = v.dut ? irq4 : irq1;
    vecCount++;
    if (actRd !== v.expRd || actIrq !== v.expIrq) begin
      missCount++;
      $display("FAIL vec%0d dut%0d off=%02h rdata got %08h want %08h irq got %0b want %0b",
               idx, v.dut, v.off, actRd, v.expRd, actIrq, v.expIrq);
    end else begin
      $display("vec%0d dut%0d rd=%0b wr=%0b off=%02h wd=%08h rdata=%08h irq=%0b ok",
               idx, v.dut, v.rd, v.wr, v.off, v.wd, actRd, actIrq);
    end
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;
    reset     = 1'b1;
    idleBuses();

    // PRESCALE=1: reset state, programming, periodic overflow
    vecs.push_back(vr(0, 8'h8, 32'h0, 0));
    vecs.push_back(vr(0, 8'h4, 32'h0, 0));
    vecs.push_back(vw(0, 8'h0, 32'hFFFFFFFC, 0));
    vecs.push_back(vw(0, 8'h4, 32'hFFFFFFFE, 0));
    vecs.push_back(vr(0, 8'h0, 32'hFFFFFFFC, 0));
    vecs.push_back(vw(0, 8'h8, 32'h3, 0));
    vecs.push_back(vr(0, 8'h4, 32'hFFFFFFFE, 0));
    vecs.push_back(vr(0, 8'h4, 32'hFFFFFFFF, 0));
    vecs.push_back(vr(0, 8'h8, 32'h7, 1));
    vecs.push_back(vr(0, 8'h4, 32'hFFFFFFFD, 1));
    // acknowledge with simultaneous read: pre-write value visible
    vecs.push_back(vrw(0, 8'h8, 32'h3, 32'h7, 1));
    vecs.push_back(vr(0, 8'h4, 32'hFFFFFFFF, 0));
    vecs.push_back(vr(0, 8'h8, 32'h7, 1));
    vecs.push_back(vr(0, 8'h4, 32'hFFFFFFFD, 1));
    vecs.push_back(vi(0, 1));
    // acknowledge on the overflow edge: pending survives
    vecs.push_back(vw(0, 8'h8, 32'h3, 1));
    vecs.push_back(vr(0, 8'h8, 32'h7, 1));
    // irq disabled through an overflow
    vecs.push_back(vw(0, 8'h8, 32'h1, 1));
    vecs.push_back(vr(0, 8'h8, 32'h1, 0));
    vecs.push_back(vr(0, 8'h4, 32'hFFFFFFFF, 0));
    vecs.push_back(vr(0, 8'h8, 32'h1, 0));
    vecs.push_back(vr(0, 8'h4, 32'hFFFFFFFD, 0));
    // collisions: TL write on a tick, TH write on an overflow
    vecs.push_back(vw(0, 8'h4, 32'h5, 0));
    vecs.push_back(vr(0, 8'h4, 32'h5, 0));
    vecs.push_back(vr(0, 8'h4, 32'h6, 0));
    vecs.push_back(vw(0, 8'h4, 32'hFFFFFFFF, 0));
    vecs.push_back(vw(0, 8'h0, 32'd10, 0));
    vecs.push_back(vr(0, 8'h4, 32'hFFFFFFFC, 0));
    vecs.push_back(vr(0, 8'h0, 32'd10, 0));
    // unmapped word
    vecs.push_back(vrw(0, 8'hC, 32'hFFFFFFFF, 32'h0, 0));
    vecs.push_back(vr(0, 8'hC, 32'h0, 0));
    vecs.push_back(vr(0, 8'h4, 32'd10, 0));
    vecs.push_back(vr(0, 8'h0, 32'd10, 0));
    vecs.push_back(vr(0, 8'h8, 32'h1, 0));
    // forced pending, then full clear
    vecs.push_back(vw(0, 8'h8, 32'h7, 0));
    vecs.push_back(vr(0, 8'h8, 32'h7, 1));
    vecs.push_back(vw(0, 8'h8, 32'h0, 1));
    vecs.push_back(vr(0, 8'h8, 32'h0, 0));
    vecs.push_back(vr(0, 8'h3, 32'd10, 0));
    vecs.push_back(vr(0, 8'h10, 32'h0, 0));

    // PRESCALE=4: overflow on 4th enabled edge, disable/re-enable restarts the prescaler
    vecs.push_back(vw(1, 8'h4, 32'hFFFFFFFF, 0));
    vecs.push_back(vw(1, 8'h0, 32'h100, 0));
    vecs.push_back(vw(1, 8'h8, 32'h3, 0));
    vecs.push_back(vr(1, 8'h4, 32'hFFFFFFFF, 0));
    vecs.push_back(vi(1, 0));
    vecs.push_back(vr(1, 8'h8, 32'h3, 0));
    vecs.push_back(vr(1, 8'h4, 32'hFFFFFFFF, 0));
    vecs.push_back(vr(1, 8'h4, 32'h100, 1));
    vecs.push_back(vw(1, 8'h8, 32'h3, 1));
    vecs.push_back(vr(1, 8'h4, 32'h100, 0));
    vecs.push_back(vr(1, 8'h4, 32'h100, 0));
    vecs.push_back(vr(1, 8'h4, 32'h101, 0));
    vecs.push_back(vi(1, 0));
    vecs.push_back(vw(1, 8'h8, 32'h2, 0));
    vecs.push_back(vr(1, 8'h8, 32'h2, 0));
    vecs.push_back(vw(1, 8'h8, 32'h3, 0));
    vecs.push_back(vr(1, 8'h4, 32'h101, 0));
    vecs.push_back(vi(1, 0));
    vecs.push_back(vr(1, 8'h4, 32'h101, 0));
    vecs.push_back(vr(1, 8'h4, 32'h101, 0));
    vecs.push_back(vr(1, 8'h4, 32'h102, 0));
    vecs.push_back(vi(1, 0));
    vecs.push_back(vi(1, 0));
    // disable lands exactly on a tick edge: no count
    vecs.push_back(vw(1, 8'h8, 32'h2, 0));
    vecs.push_back(vr(1, 8'h4, 32'h102, 0));
    vecs.push_back(vw(1, 8'h8, 32'h3, 0));
    vecs.push_back(vr(1, 8'h4, 32'h102, 0));
    vecs.push_back(vi(1, 0));
    vecs.push_back(vi(1, 0));
    vecs.push_back(vr(1, 8'h4, 32'h102, 0));
    vecs.push_back(vr(1, 8'h4, 32'h103, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) applyVec(i, vecs[i]);

    // Reset mid-count with a concurrent TCON store: reset must win
    applyVec(900, vw(0, 8'h0, 32'h55, 0));
    applyVec(901, vw(0, 8'h8, 32'h3, 0));
    applyVec(902, vi(0, 0));
    applyVec(903, vi(0, 0));
    @(negedge clk);
    idleBuses();
    reset = 1'b1;
    bus1.addr = BASE + 32'h8; bus1.MemWrite = 1'b1; bus1.wdata = 32'h7;
    @(negedge clk);
    reset = 1'b0;
    idleBuses();
    #1;
    checkVal("rst_irq1", {31'h0, irq1}, 32'h0);
    checkVal("rst_irq4", {31'h0, irq4}, 32'h0);
    checkVal("rst_rdata_idle", bus1.rdata, 32'h0);
    applyVec(910, vr(0, 8'h0, 32'h0, 0));
    applyVec(911, vr(0, 8'h4, 32'h0, 0));
    applyVec(912, vr(0, 8'h8, 32'h0, 0));
    applyVec(913, vr(1, 8'h8, 32'h0, 0));
    applyVec(914, vr(1, 8'h4, 32'h0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
